// File: rtl/ahbl_to_apb4_split.sv
// rtl/ahbl_to_apb4_split.sv - AHB-Lite slave to multi-port APB4 master bridge
module ahbl_to_apb4_split #(
   parameter int W_HADDR  = 32,
   parameter int W_PADDR  = 16,
   parameter int W_DATA   = 32,
   parameter int N_SLAVES = 4,
   parameter int TIMEOUT  = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ahbls_hready,
   output logic                         ahbls_hready_resp,
   output logic                         ahbls_hresp,
   input  logic [W_HADDR-1:0]           ahbls_haddr,
   input  logic                         ahbls_hwrite,
   input  logic [1:0]                   ahbls_htrans,
   input  logic [2:0]                   ahbls_hsize,
   input  logic [2:0]                   ahbls_hburst,
   input  logic [3:0]                   ahbls_hprot,
   input  logic                         ahbls_hmastlock,
   input  logic [W_DATA-1:0]            ahbls_hwdata,
   output logic [W_DATA-1:0]            ahbls_hrdata,
   output logic [W_PADDR-1:0]           apbm_paddr,
   output logic [N_SLAVES-1:0]          apbm_psel,
   output logic                         apbm_penable,
   output logic                         apbm_pwrite,
   output logic [W_DATA-1:0]            apbm_pwdata,
   output logic [W_DATA/8-1:0]          apbm_pstrb,
   output logic [2:0]                   apbm_pprot,
   input  logic [N_SLAVES-1:0]          apbm_pready,
   input  logic [N_SLAVES*W_DATA-1:0]   apbm_prdata,
   input  logic [N_SLAVES-1:0]          apbm_pslverr
);

   localparam int W_IDX  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int N_LANE = W_DATA / 8;
   localparam int W_LANE = $clog2(N_LANE);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR0, S_ERR1} state_t;

   state_t              state;
   logic [W_IDX-1:0]    idx;
   logic [W_DATA-1:0]   pwdata_q;
   logic [31:0]         to_cnt;

   logic [W_IDX-1:0]    a_idx;
   logic                a_bad;
   logic                accept;
   logic [N_LANE-1:0]   a_strb;
   logic                cur_ready;
   logic                cur_err;
   logic                next_phase;
   logic                unused;

   assign unused = ^{ahbls_hburst, ahbls_hmastlock, ahbls_htrans[0], ahbls_hprot[3:2],
                     ahbls_haddr[W_HADDR-1:W_PADDR+W_IDX]};

   // psel is one-hot and only set during SETUP/ACCESS, so it selects the active port directly
   assign cur_ready  = |(apbm_pready & apbm_psel);
   assign cur_err    = |(apbm_pslverr & apbm_psel);
   assign a_idx      = ahbls_haddr[W_PADDR +: W_IDX];
   assign accept     = ahbls_hready && ahbls_htrans[1];
   assign a_bad      = (int'(a_idx) >= N_SLAVES) || ((8 << ahbls_hsize) > W_DATA);
   assign next_phase = (state == S_IDLE) || (state == S_ERR1) ||
                       ((state == S_ACCESS) && cur_ready && !cur_err);
   assign apbm_pwdata = (state == S_SETUP) ? ahbls_hwdata : pwdata_q;

   // write strobes: 2**hsize contiguous lanes from the size-aligned byte offset
   always_comb begin
      int lanes;
      int base;
      lanes  = 1 << ahbls_hsize;
      base   = int'(ahbls_haddr[W_LANE-1:0]) & ~(lanes - 1);
      a_strb = '0;
      for (int i = 0; i < N_LANE; i++) begin
         if (ahbls_hwrite && i >= base && i < base + lanes) a_strb[i] = 1'b1;
      end
   end

   // read data muxed from the latched port; an unpopulated index reads as zero
   always_comb begin
      ahbls_hrdata = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (int'(idx) == i) ahbls_hrdata = apbm_prdata[i*W_DATA +: W_DATA];
      end
   end

   // AHB handshake: stall through SETUP and waited ACCESS, two-cycle error response
   always_comb begin
      ahbls_hready_resp = 1'b1;
      ahbls_hresp       = 1'b0;
      case (state)
         S_SETUP:  ahbls_hready_resp = 1'b0;
         S_ACCESS: ahbls_hready_resp = cur_ready && !cur_err;
         S_ERR0: begin
            ahbls_hready_resp = 1'b0;
            ahbls_hresp       = 1'b1;
         end
         S_ERR1:   ahbls_hresp = 1'b1;
         default: ;
      endcase
   end

   // bridge FSM and registered APB outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         idx          <= '0;
         apbm_psel    <= '0;
         apbm_penable <= 1'b0;
         apbm_pwrite  <= 1'b0;
         apbm_paddr   <= '0;
         pwdata_q     <= '0;
         apbm_pstrb   <= '0;
         apbm_pprot   <= '0;
         to_cnt       <= '0;
      end else begin
         case (state)
            S_SETUP: begin
               pwdata_q     <= ahbls_hwdata;
               apbm_penable <= 1'b1;
               to_cnt       <= '0;
               state        <= S_ACCESS;
            end
            S_ACCESS: begin
               if (cur_ready) begin
                  apbm_penable <= 1'b0;
                  if (cur_err) begin
                     apbm_psel <= '0;
                     state     <= S_ERR0;
                  end
               end else begin
                  to_cnt <= to_cnt + 32'd1;
                  if (TIMEOUT > 0 && to_cnt + 32'd1 == 32'(TIMEOUT)) begin
                     apbm_psel    <= '0;
                     apbm_penable <= 1'b0;
                     state        <= S_ERR0;
                  end
               end
            end
            S_ERR0: state <= S_ERR1;
            default: ;
         endcase
         // a completed beat, an idle slot or the last error cycle may take the next address phase
         if (next_phase) begin
            if (accept) begin
               idx <= a_idx;
               if (a_bad) begin
                  apbm_psel <= '0;
                  state     <= S_ERR0;
               end else begin
                  apbm_psel   <= N_SLAVES'(1) << a_idx;
                  apbm_paddr  <= ahbls_haddr[W_PADDR-1:0];
                  apbm_pwrite <= ahbls_hwrite;
                  apbm_pstrb  <= a_strb;
                  apbm_pprot  <= {~ahbls_hprot[0], 1'b1, ahbls_hprot[1]};
                  state       <= S_SETUP;
               end
            end else begin
               apbm_psel <= '0;
               state     <= S_IDLE;
            end
         end
      end
   end

endmodule
